// File: rtl/chess_board_store.sv
// Chess board storage: per-square piece codes, direct writes, two-edge moves
// with capture recording, bounded undo history and a starting-layout sequencer.
//
// Command handshake: a command is taken on the rising CLK edge where
// cmd_valid and cmd_ready are both high. cmd_ready is high only in IDLE. The
// requester holds cmd_valid and all cmd_* fields stable until that edge. An
// init_start in the same IDLE cycle takes priority and the command is not taken.
module chess_board_store #(
  parameter  int ROW_BITS   = 3,
  parameter  int PIECE_W    = 4,
  parameter  int HIST_DEPTH = 16,
  localparam int ADDR_W     = ROW_BITS + 3,
  localparam int HC_W       = $clog2(HIST_DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               init_start,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_src,
  input  logic [ADDR_W-1:0]  cmd_dst,
  input  logic [PIECE_W-1:0] cmd_piece,
  input  logic [ADDR_W-1:0]  logic_addr,
  output logic [PIECE_W-1:0] logic_piece,
  input  logic [ADDR_W-1:0]  disp_addr,
  output logic [PIECE_W-1:0] disp_piece,
  output logic               busy,
  output logic               move_done,
  output logic [PIECE_W-1:0] captured_piece,
  output logic               error,
  output logic [HC_W-1:0]    hist_count,
  output logic [1:0]         dbg_state
);

  localparam int ROWS = 2 ** ROW_BITS;
  localparam int NSQ  = ROWS * 8;
  localparam int HP_W = $clog2(HIST_DEPTH);
  // Moves carry only color and type; wider code bits are cleared.
  localparam logic [PIECE_W-1:0] CODE_MASK = PIECE_W'(4'hF);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_MOVE2 = 2'd2,
    S_UNDO2 = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_idx_q, init_idx_d;
  logic [PIECE_W-1:0]  board_q [NSQ];

  // Operation in flight between the two edges of a move or undo.
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [PIECE_W-1:0]  cap_q, cap_d;

  logic [PIECE_W-1:0]  captured_q, captured_d;
  logic                move_done_q, move_done_d;
  logic                error_q, error_d;
  logic [PIECE_W-1:0]  disp_q;

  // History circular buffer; wp points at the next free slot.
  logic [ADDR_W-1:0]   hist_src_q [HIST_DEPTH];
  logic [ADDR_W-1:0]   hist_dst_q [HIST_DEPTH];
  logic [PIECE_W-1:0]  hist_cap_q [HIST_DEPTH];
  logic [HP_W-1:0]     hist_wp_q;
  logic [HC_W-1:0]     hist_cnt_q;
  logic [HP_W-1:0]     hist_top;

  // Single board write port, shared by every state.
  logic                board_we;
  logic [ADDR_W-1:0]   board_waddr;
  logic [PIECE_W-1:0]  board_wdata;
  logic                hist_push, hist_pop, hist_clr;

  // Starting layout: black on rows 0/1, white on the last two rows.
  function automatic logic [PIECE_W-1:0] layout_piece(input logic [ADDR_W-1:0] idx);
    logic [ROW_BITS-1:0] row;
    logic [2:0]          col;
    logic [2:0]          back;
    logic [3:0]          code;
    row = idx[ADDR_W-1:3];
    col = idx[2:0];
    case (col)
      3'd0, 3'd7: back = 3'd4;
      3'd1, 3'd6: back = 3'd2;
      3'd2, 3'd5: back = 3'd3;
      3'd3:       back = 3'd5;
      default:    back = 3'd6;
    endcase
    code = 4'h0;
    if (row == ROW_BITS'(0))             code = {1'b1, back};
    else if (row == ROW_BITS'(1))        code = 4'h9;
    else if (row == ROW_BITS'(ROWS - 2)) code = 4'h1;
    else if (row == ROW_BITS'(ROWS - 1)) code = {1'b0, back};
    return PIECE_W'(code);
  endfunction

  assign hist_top = hist_wp_q - HP_W'(1);

  // Next-state, board write port and history control.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cap_d       = cap_q;
    captured_d  = captured_q;
    move_done_d = 1'b0;
    error_d     = 1'b0;
    board_we    = 1'b0;
    board_waddr = cmd_dst;
    board_wdata = cmd_piece;
    hist_push   = 1'b0;
    hist_pop    = 1'b0;
    hist_clr    = 1'b0;
    case (state_q)
      S_INIT: begin
        board_we    = 1'b1;
        board_waddr = init_idx_q;
        board_wdata = layout_piece(init_idx_q);
        if (init_idx_q == ADDR_W'(NSQ - 1)) state_d = S_IDLE;
        else init_idx_d = init_idx_q + ADDR_W'(1);
      end
      S_IDLE: begin
        if (init_start) begin
          state_d    = S_INIT;
          init_idx_d = '0;
          hist_clr   = 1'b1;
        end else if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              board_we    = 1'b1;
              board_waddr = cmd_dst;
              board_wdata = cmd_piece;
              hist_clr    = 1'b1;
            end
            2'b01: begin
              if (cmd_src == cmd_dst || board_q[cmd_src][2:0] == 3'd0) begin
                error_d = 1'b1;
              end else begin
                board_we    = 1'b1;
                board_waddr = cmd_dst;
                board_wdata = board_q[cmd_src] & CODE_MASK;
                src_d       = cmd_src;
                dst_d       = cmd_dst;
                cap_d       = board_q[cmd_dst];
                captured_d  = board_q[cmd_dst];
                state_d     = S_MOVE2;
              end
            end
            2'b10: begin
              if (hist_cnt_q == '0) begin
                error_d = 1'b1;
              end else begin
                hist_pop    = 1'b1;
                src_d       = hist_src_q[hist_top];
                dst_d       = hist_dst_q[hist_top];
                cap_d       = hist_cap_q[hist_top];
                board_we    = 1'b1;
                board_waddr = hist_src_q[hist_top];
                board_wdata = board_q[hist_dst_q[hist_top]];
                state_d     = S_UNDO2;
              end
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      S_MOVE2: begin
        board_we    = 1'b1;
        board_waddr = src_q;
        board_wdata = '0;
        hist_push   = 1'b1;
        move_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_UNDO2: begin
        board_we    = 1'b1;
        board_waddr = dst_q;
        board_wdata = cap_q;
        captured_d  = cap_q;
        move_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // State, board, status pulses and history pointers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_INIT;
      init_idx_q  <= '0;
      for (int i = 0; i < NSQ; i++) board_q[i] <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      cap_q       <= '0;
      captured_q  <= '0;
      move_done_q <= 1'b0;
      error_q     <= 1'b0;
      disp_q      <= '0;
      hist_wp_q   <= '0;
      hist_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      if (board_we) board_q[board_waddr] <= board_wdata;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cap_q       <= cap_d;
      captured_q  <= captured_d;
      move_done_q <= move_done_d;
      error_q     <= error_d;
      disp_q      <= board_q[disp_addr];
      if (hist_clr) begin
        hist_wp_q  <= '0;
        hist_cnt_q <= '0;
      end else if (hist_push) begin
        hist_wp_q <= hist_wp_q + HP_W'(1);
        if (hist_cnt_q != HC_W'(HIST_DEPTH)) hist_cnt_q <= hist_cnt_q + HC_W'(1);
      end else if (hist_pop) begin
        hist_wp_q  <= hist_wp_q - HP_W'(1);
        hist_cnt_q <= hist_cnt_q - HC_W'(1);
      end
    end
  end

  // History storage; validity is tracked by hist_cnt_q, so no reset needed.
  always_ff @(posedge CLK) begin
    if (hist_push) begin
      hist_src_q[hist_wp_q] <= src_q;
      hist_dst_q[hist_wp_q] <= dst_q;
      hist_cap_q[hist_wp_q] <= cap_q;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q == S_INIT);
  assign logic_piece    = board_q[logic_addr];
  assign disp_piece     = disp_q;
  assign move_done      = move_done_q;
  assign captured_piece = captured_q;
  assign error          = error_q;
  assign hist_count     = hist_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_chess_board_store.sv
// Bench for chess_board_store: directed scenarios plus random commands
// checked against a square-array / history-queue model of the board.
module tb_chess_board_store;

  localparam int ROW_BITS = 3, PIECE_W = 4, HIST_DEPTH = 4;
  localparam int ADDR_W = 6, NSQ = 64, HC_W = 3;

  logic CLK, RESET_N, init_start, cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [ADDR_W-1:0] cmd_src, cmd_dst, logic_addr, disp_addr;
  logic [PIECE_W-1:0] cmd_piece, logic_piece, disp_piece, captured_piece;
  logic busy, move_done, error;
  logic [HC_W-1:0] hist_count;
  logic [1:0] dbg_state;

  chess_board_store #(.ROW_BITS(ROW_BITS), .PIECE_W(PIECE_W), .HIST_DEPTH(HIST_DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .init_start(init_start), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_piece(cmd_piece), .logic_addr(logic_addr), .logic_piece(logic_piece),
    .disp_addr(disp_addr), .disp_piece(disp_piece), .busy(busy), .move_done(move_done),
    .captured_piece(captured_piece), .error(error), .hist_count(hist_count),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model
  typedef struct { logic [5:0] src; logic [5:0] dst; logic [3:0] cap; } hist_t;
  logic [3:0] model_board [64];
  logic [3:0] dut_board [64];
  hist_t      model_hist [$];
  logic [3:0] model_cap;
  logic [3:0] exp_q [$];

  function automatic logic [3:0] ref_layout(input int sq);
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    int row = sq / 8;
    int col = sq % 8;
    if (row == 0) return 4'(8 + back[col]);
    if (row == 1) return 4'h9;
    if (row == 6) return 4'h1;
    if (row == 7) return 4'(back[col]);
    return 4'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_board[i] = 4'h0;
    model_hist.delete();
    model_cap = 4'h0;
  endtask

  task automatic model_layout();
    for (int i = 0; i < 64; i++) model_board[i] = ref_layout(i);
    model_hist.delete();
  endtask

  task automatic model_exec(input logic [1:0] op, input logic [5:0] src, input logic [5:0] dst,
                            input logic [3:0] pc, output bit err, output bit done);
    hist_t e;
    err = 0;
    done = 0;
    case (op)
      2'b00: begin model_board[dst] = pc; model_hist.delete(); end
      2'b01: begin
        if (src == dst || model_board[src][2:0] == 3'd0) err = 1;
        else begin
          e.src = src; e.dst = dst; e.cap = model_board[dst];
          model_board[dst] = model_board[src];
          model_board[src] = 4'h0;
          model_hist.push_back(e);
          if (model_hist.size() > HIST_DEPTH) void'(model_hist.pop_front());
          model_cap = e.cap;
          done = 1;
        end
      end
      2'b10: begin
        if (model_hist.size() == 0) err = 1;
        else begin
          e = model_hist.pop_back();
          model_board[e.src] = model_board[e.dst];
          model_board[e.dst] = e.cap;
          model_cap = e.cap;
          done = 1;
        end
      end
      default: err = 1;
    endcase
  endtask

  // Driver tasks
  task automatic send(input logic [1:0] op, input logic [5:0] src, input logic [5:0] dst,
                      input logic [3:0] pc);
    int n = 0;
    @(negedge CLK);
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
    if (cmd_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_piece = pc; cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic peek(input logic [5:0] a, output logic [3:0] v);
    logic_addr = a;
    #1;
    v = logic_piece;
  endtask

  task automatic snap_board();
    for (int i = 0; i < 64; i++) begin
      logic_addr = 6'(i);
      #1;
      dut_board[i] = logic_piece;
    end
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    do begin
      @(posedge CLK);
      #1;
      cycles++;
    end while (busy === 1'b1 && cycles < 200);
  endtask

  // Tests
  task automatic test_reset();
    int bad = 0;
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    model_reset();
    n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else n_pass++;
    n_checks++; if (move_done !== 1'b0 || error !== 1'b0)
      $display("FAIL reset_pulses: move_done=%b error=%b want 0 0", move_done, error); else n_pass++;
    n_checks++; if (captured_piece !== 4'h0 || disp_piece !== 4'h0)
      $display("FAIL reset_pieces: captured=%h disp=%h want 0 0", captured_piece, disp_piece); else n_pass++;
    n_checks++; if (hist_count !== 3'd0) $display("FAIL reset_hist: got %0d want 0", hist_count); else n_pass++;
    n_checks++; if ($isunknown(dbg_state)) $display("FAIL reset_dbg_state: got %b want known", dbg_state); else n_pass++;
    snap_board();
    for (int i = 0; i < 64; i++) if (dut_board[i] !== model_board[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL reset_board: %0d squares nonzero, want 0", bad); else n_pass++;
  endtask

  task automatic test_init_layout();
    int cyc, bad = 0;
    logic [3:0] v;
    @(negedge CLK);
    RESET_N = 1'b1;
    wait_init(cyc);
    model_layout();
    n_checks++; if (cyc != 64) $display("FAIL init_cycles: busy fell after %0d cycles, want 64", cyc); else n_pass++;
    peek(6'h04, v);
    n_checks++; if (v !== 4'hE) $display("FAIL init_sq04: got %h want e", v); else n_pass++;
    peek(6'h3B, v);
    n_checks++; if (v !== 4'h5) $display("FAIL init_sq3b: got %h want 5", v); else n_pass++;
    peek(6'h20, v);
    n_checks++; if (v !== 4'h0) $display("FAIL init_sq20: got %h want 0", v); else n_pass++;
    snap_board();
    for (int i = 0; i < 64; i++) if (dut_board[i] !== model_board[i]) bad++;
    n_checks++; if (bad != 0 || cmd_ready !== 1'b1)
      $display("FAIL init_board: %0d bad squares, ready=%b, want 0 and 1", bad, cmd_ready); else n_pass++;
  endtask

  task automatic test_move();
    bit err, done;
    logic [3:0] v24, v34;
    send(2'b01, 6'h34, 6'h24, 4'h0);
    model_exec(2'b01, 6'h34, 6'h24, 4'h0, err, done);
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL move_ready_low: got %b want 0", cmd_ready); else n_pass++;
    init_start = 1'b1;   // must be ignored outside IDLE
    @(posedge CLK);
    #1;
    init_start = 1'b0;
    n_checks++; if (move_done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL move_done: done=%b ready=%b busy=%b want 1 1 0", move_done, cmd_ready, busy); else n_pass++;
    peek(6'h24, v24);
    peek(6'h34, v34);
    n_checks++; if (v24 !== model_board[6'h24] || v34 !== model_board[6'h34] || hist_count !== 3'(model_hist.size()))
      $display("FAIL move_board: sq24=%h sq34=%h hist=%0d want %h %h %0d", v24, v34, hist_count,
               model_board[6'h24], model_board[6'h34], model_hist.size()); else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++; if (move_done !== 1'b0) $display("FAIL move_done_width: got %b want 0", move_done); else n_pass++;
  endtask

  task automatic test_capture_undo();
    bit err, done;
    logic [3:0] v, v2;
    send(2'b00, 6'h00, 6'h1C, 4'h9);
    model_exec(2'b00, 6'h00, 6'h1C, 4'h9, err, done);
    peek(6'h1C, v);
    n_checks++; if (v !== 4'h9 || hist_count !== 3'd0)
      $display("FAIL write_sq1c: got %h hist=%0d want 9 0", v, hist_count); else n_pass++;
    send(2'b01, 6'h24, 6'h1C, 4'h0);
    model_exec(2'b01, 6'h24, 6'h1C, 4'h0, err, done);
    @(posedge CLK);
    #1;
    n_checks++; if (move_done !== 1'b1 || captured_piece !== model_cap || hist_count !== 3'd1)
      $display("FAIL capture_move: done=%b cap=%h hist=%0d want 1 %h 1", move_done, captured_piece,
               hist_count, model_cap); else n_pass++;
    send(2'b10, 6'h00, 6'h00, 4'h0);
    model_exec(2'b10, 6'h00, 6'h00, 4'h0, err, done);
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL undo_ready_low: got %b want 0", cmd_ready); else n_pass++;
    @(posedge CLK);
    #1;
    peek(6'h1C, v);
    peek(6'h24, v2);
    n_checks++; if (move_done !== 1'b1 || captured_piece !== 4'h9 || v !== 4'h9 || v2 !== 4'h1 || hist_count !== 3'd0)
      $display("FAIL undo_result: done=%b cap=%h sq1c=%h sq24=%h hist=%0d want 1 9 9 1 0",
               move_done, captured_piece, v, v2, hist_count); else n_pass++;
  endtask

  task automatic test_errors();
    logic [1:0] ops [4] = '{2'b10, 2'b01, 2'b01, 2'b11};
    logic [5:0] srcs [4] = '{6'h00, 6'h20, 6'h30, 6'h10};
    logic [5:0] dsts [4] = '{6'h00, 6'h28, 6'h30, 6'h18};
    bit err, done;
    int bad = 0;
    for (int k = 0; k < 4; k++) begin
      send(ops[k], srcs[k], dsts[k], 4'h7);
      model_exec(ops[k], srcs[k], dsts[k], 4'h7, err, done);
      n_checks++; if (error !== err || cmd_ready !== 1'b1)
        $display("FAIL error_case%0d: error=%b ready=%b want %b 1", k, error, cmd_ready, err); else n_pass++;
      @(posedge CLK);
      #1;
      n_checks++; if (error !== 1'b0) $display("FAIL error_width%0d: got %b want 0", k, error); else n_pass++;
    end
    snap_board();
    for (int i = 0; i < 64; i++) if (dut_board[i] !== model_board[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL error_board: %0d squares changed, want 0", bad); else n_pass++;
  endtask

  task automatic test_disp();
    bit err, done;
    logic [3:0] old_v;
    @(negedge CLK);
    disp_addr = 6'h3C;
    @(posedge CLK);
    #1;
    n_checks++; if (disp_piece !== model_board[6'h3C])
      $display("FAIL disp_read: got %h want %h", disp_piece, model_board[6'h3C]); else n_pass++;
    disp_addr = 6'h21;
    old_v = model_board[6'h21];
    send(2'b00, 6'h00, 6'h21, 4'h3);
    model_exec(2'b00, 6'h00, 6'h21, 4'h3, err, done);
    n_checks++; if (disp_piece !== old_v) $display("FAIL disp_before_write: got %h want %h", disp_piece, old_v); else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++; if (disp_piece !== 4'h3) $display("FAIL disp_after_write: got %h want 3", disp_piece); else n_pass++;
  endtask

  task automatic test_overflow();
    bit err, done;
    int cyc, bad = 0;
    int exp_h;
    @(negedge CLK);
    init_start = 1'b1;
    @(posedge CLK);
    #1;
    init_start = 1'b0;
    n_checks++; if (busy !== 1'b1 || hist_count !== 3'd0)
      $display("FAIL reinit_start: busy=%b hist=%0d want 1 0", busy, hist_count); else n_pass++;
    wait_init(cyc);
    model_layout();
    n_checks++; if (cyc != 64) $display("FAIL reinit_cycles: got %0d want 64", cyc); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      send(2'b01, 6'(6'h30 + k), 6'(6'h28 + k), 4'h0);
      model_exec(2'b01, 6'(6'h30 + k), 6'(6'h28 + k), 4'h0, err, done);
      @(posedge CLK);
      #1;
      exp_h = (k + 1 > HIST_DEPTH) ? HIST_DEPTH : k + 1;
      n_checks++; if (move_done !== 1'b1 || hist_count !== 3'(exp_h))
        $display("FAIL ovf_move%0d: done=%b hist=%0d want 1 %0d", k, move_done, hist_count, exp_h); else n_pass++;
    end
    for (int k = 0; k < 5; k++) begin
      send(2'b10, 6'h00, 6'h00, 4'h0);
      model_exec(2'b10, 6'h00, 6'h00, 4'h0, err, done);
      if (err) begin
        n_checks++; if (error !== 1'b1 || hist_count !== 3'd0)
          $display("FAIL ovf_undo_err%0d: error=%b hist=%0d want 1 0", k, error, hist_count); else n_pass++;
      end else begin
        @(posedge CLK);
        #1;
        n_checks++; if (move_done !== 1'b1 || hist_count !== 3'(model_hist.size()) || captured_piece !== model_cap)
          $display("FAIL ovf_undo%0d: done=%b hist=%0d cap=%h want 1 %0d %h", k, move_done, hist_count,
                   captured_piece, model_hist.size(), model_cap); else n_pass++;
      end
    end
    snap_board();
    for (int i = 0; i < 64; i++) if (dut_board[i] !== model_board[i]) bad++;
    n_checks++; if (bad != 0 || dut_board[6'h28] !== 4'h1 || dut_board[6'h30] !== 4'h0)
      $display("FAIL ovf_board: %0d bad squares, sq28=%h sq30=%h want 0 1 0", bad,
               dut_board[6'h28], dut_board[6'h30]); else n_pass++;
  endtask

  task automatic test_random();
    bit err, done;
    int r, bad = 0;
    logic [1:0] op;
    logic [5:0] s, d;
    logic [3:0] pc, v;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      op = (r == 0) ? 2'b00 : (r <= 6) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
      s = 6'($urandom_range(0, 63));
      d = 6'($urandom_range(0, 63));
      pc = 4'($urandom_range(0, 15));
      send(op, s, d, pc);
      model_exec(op, s, d, pc, err, done);
      if (done) exp_q.push_back(model_cap);
      if (err) begin
        n_checks++; if (error !== 1'b1) $display("FAIL rnd_error%0d: got %b want 1", it, error); else n_pass++;
      end else if (done) begin
        @(posedge CLK);
        #1;
        v = exp_q.pop_front();
        n_checks++; if (move_done !== 1'b1 || captured_piece !== v)
          $display("FAIL rnd_done%0d: done=%b cap=%h want 1 %h", it, move_done, captured_piece, v); else n_pass++;
      end else begin
        peek(d, v);
        n_checks++; if (error !== 1'b0 || v !== pc)
          $display("FAIL rnd_write%0d: error=%b sq=%h want 0 %h", it, error, v, pc); else n_pass++;
      end
      n_checks++; if (hist_count !== 3'(model_hist.size()))
        $display("FAIL rnd_hist%0d: got %0d want %0d", it, hist_count, model_hist.size()); else n_pass++;
    end
    snap_board();
    for (int i = 0; i < 64; i++) if (dut_board[i] !== model_board[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL rnd_board: %0d squares differ from model", bad); else n_pass++;
  endtask

  task automatic test_mid_move_reset();
    int src = 0, cyc, bad = 0;
    for (int i = 63; i >= 0; i--) if (model_board[i][2:0] != 3'd0) src = i;
    send(2'b01, 6'(src), 6'((src + 1) % 64), 4'h0);
    #1;
    RESET_N = 1'b0;
    #1;
    model_reset();
    n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || move_done !== 1'b0 || error !== 1'b0)
      $display("FAIL midrst_ctrl: busy=%b ready=%b done=%b err=%b want 1 0 0 0", busy, cmd_ready,
               move_done, error); else n_pass++;
    n_checks++; if (captured_piece !== 4'h0 || disp_piece !== 4'h0 || hist_count !== 3'd0)
      $display("FAIL midrst_data: cap=%h disp=%h hist=%0d want 0 0 0", captured_piece, disp_piece,
               hist_count); else n_pass++;
    @(negedge CLK);
    RESET_N = 1'b1;
    wait_init(cyc);
    model_layout();
    n_checks++; if (cyc != 64) $display("FAIL midrst_cycles: got %0d want 64", cyc); else n_pass++;
    snap_board();
    for (int i = 0; i < 64; i++) if (dut_board[i] !== model_board[i]) bad++;
    n_checks++; if (bad != 0 || hist_count !== 3'd0)
      $display("FAIL midrst_board: %0d bad squares hist=%0d want 0 0", bad, hist_count); else n_pass++;
  endtask

  initial begin
    RESET_N = 1'b0; init_start = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_src = '0; cmd_dst = '0; cmd_piece = '0; logic_addr = '0; disp_addr = '0;
    test_reset();
    test_init_layout();
    test_move();
    test_capture_undo();
    test_errors();
    test_disp();
    test_overflow();
    test_random();
    test_mid_move_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
